ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Behavioural/synthesizable RAM slave at the far end of the memory-control-to-RAM interface.
- Accepts the single-port request (ramaddr, ramstore, ramWEN, ramREN) issued by the arbiter.
- Reports progress on ramstate (FREE/BUSY/ACCESS/ERROR) after a programmable wait latency.
- Returns read data on ramload and commits writes.
- Used in the CPU top-level simulation and on FPGA in place of the vendor RAM.

Parameters:
- LAT, 2, BUSY cycles inserted after the request's first cycle; 0 is legal.
- DEPTH, 1024, number of 32-bit words; byte address bits [1:0] are ignored.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-high. The port keeps the codebase name nRST, but the polarity is high.
- ramaddr  in  32  byte address (word_t).
- ramstore  in  32  write data (word_t).
- ramWEN  in  1  write request.
- ramREN  in  1  read request.
- ramload  out  32  read data (word_t).
- ramstate  out  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Definitions:
  - req = ramWEN | ramREN.
  - idx = ramaddr[31:2].
  - err = (ramWEN & ramREN) | (idx >= DEPTH).
- Registered state: FSM {IDLE, WAIT, ACC}, counter cnt (clog2(LAT+1) bits), latched lat_idx and lat_wen.
- Match condition (match) is true when req & ~err & idx==lat_idx & ramWEN==lat_wen.
- Reset (nRST high, asynchronous):
  - state=IDLE, cnt=0, lat_idx=0, lat_wen=0.
  - All memory words = 0.
  - While reset is held: ramstate=FREE, ramload=0.
- ramstate (combinational, priority order):
  - err gives ERROR.
  - else ~req gives FREE.
  - else state==ACC & match gives ACCESS.
  - else BUSY.
- IDLE:
  - req & ~err: latch idx/ramWEN. Go to ACC if LAT==0, else go to WAIT with cnt=LAT-1.
  - Otherwise stay in IDLE.
- WAIT:
  - ~req or err: go to IDLE.
  - Request present but not matching (address or op changed): relatch, reload cnt=LAT-1, stay in WAIT.
  - Match and cnt==0: go to ACC.
  - Otherwise cnt--.
- ACC (exactly one cycle):
  - If match:
    - Read: ramload = mem[lat_idx] (combinational).
    - Write: mem[lat_idx] <= ramstore on the closing edge.
    - Next state: IDLE.
  - If not match: treat as a new request. Relatch, then go to WAIT, or to ACC if LAT==0. No write commits.
- Latency:
  - A stable request first seen in cycle t is BUSY in cycles t..t+LAT and ACCESS in cycle t+LAT+1.
  - Minimum of 2 cycles per access (LAT=0).
  - Back-to-back requests always pass through IDLE (one BUSY cycle).
- ramload = 0 whenever ramstate != ACCESS or the op is a write.
- Read-after-write: a read in the access following a write returns the new data.
- Error:
  - No memory change and no latch update; next state is IDLE.
  - ERROR holds for as long as err holds.
- Reset mid-WAIT or mid-ACC: the access is abandoned and a pending write is not committed.
- ramstore is sampled only at the ACC closing edge.

Decomposition:
- cpu_types_pkg already provides word_t and ramstate_t; reuse them.
- Add to cpu_types_pkg: RAM_LAT_DEFAULT=2, RAM_DEPTH_DEFAULT=1024.
- Add a localparam IDX_W = clog2(DEPTH).
- The FSM state enum stays local to the module.
- One natural sub-module: ram_array.
  - DEPTH x 32 storage.
  - Synchronous write port, combinational read port, asynchronous clear on reset.
- Keep the FSM and counter in ram_responder.

Test Plan:
- LAT=2, reset then ramREN=1, ramaddr=0x40 held: ramstate BUSY for 3 cycles, ACCESS in the 4th with ramload=0, FREE after the request drops.
- Write ramaddr=0x40, ramstore=0xDEADBEEF, then read 0x40: write gets ACCESS at cycle 4; the read's ACCESS returns 0xDEADBEEF; ramaddr=0x41 returns the same word.
- Read 0x10 with the address switched to 0x20 after 2 BUSY cycles: counter restarts, ACCESS arrives 3 cycles after the switch, data is mem[0x20>>2].
- ramWEN=ramREN=1 at 0x0, and separately ramaddr=DEPTH*4: ERROR every cycle of assertion, no memory change (read back 0).
- Write 0x8 with value 0x1234, asserting nRST in the cycle before ACCESS: ramstate=FREE and ramload=0 during reset; a later read of 0x8 returns 0.
- LAT=0 build, alternating reads and writes on 0x0/0x4: each access takes BUSY then ACCESS (2 cycles), data is consistent.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state, RAM defaults.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT   = 2;
    localparam int RAM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/ram_array.sv
// Word storage for ram_responder: sync write, async read, async clear.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// RAM slave behind the memory arbiter: wait-state FSM in front of ram_array.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int DEPTH = RAM_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        ramWEN,
    input  logic        ramREN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RLD = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2
    } fsm_t;

    fsm_t             state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] lat_idx, lidx_n;
    logic             lat_wen, lwen_n;

    logic [31:0]      widx;
    logic [IDX_W-1:0] idx;
    logic             req, err, match, we;
    logic [31:0]      rdata;
    ramstate_t        st;
    logic             unused;

    assign widx   = {2'b00, ramaddr[31:2]};
    assign idx    = ramaddr[IDX_W+1:2];
    assign req    = ramWEN | ramREN;
    assign err    = (ramWEN & ramREN) | (widx >= 32'(DEPTH));
    assign match  = req & ~err & (idx == lat_idx) & (ramWEN == lat_wen);
    assign unused = ^ramaddr[1:0];

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_idx <= '0;
            lat_wen <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lat_idx <= lidx_n;
            lat_wen <= lwen_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lidx_n  = lat_idx;
        lwen_n  = lat_wen;
        we      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && !err) begin
                    lidx_n  = idx;
                    lwen_n  = ramWEN;
                    cnt_n   = CNT_RLD;
                    state_n = (LAT == 0) ? ACC : WAIT;
                end
            end
            WAIT: begin
                if (!req || err) begin
                    state_n = IDLE;
                end else if (!match) begin
                    lidx_n = idx;
                    lwen_n = ramWEN;
                    cnt_n  = CNT_RLD;
                end else if (cnt == '0) begin
                    state_n = ACC;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACC: begin
                // A changed request restarts the wait instead of committing.
                if (match) begin
                    we      = lat_wen;
                    state_n = IDLE;
                end else if (req && !err) begin
                    lidx_n  = idx;
                    lwen_n  = ramWEN;
                    cnt_n   = CNT_RLD;
                    state_n = (LAT == 0) ? ACC : WAIT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        st = BUSY;
        if (nRST) begin
            st = FREE;
        end else if (err) begin
            st = ERROR;
        end else if (!req) begin
            st = FREE;
        end else if (state == ACC && match) begin
            st = ACCESS;
        end
    end

    assign ramstate = st;
    assign ramload  = (st == ACCESS && !lat_wen) ? rdata : '0;

    ram_array #(
        .DEPTH(DEPTH),
        .AW   (IDX_W)
    ) u_array (
        .CLK  (CLK),
        .nRST (nRST),
        .we   (we),
        .waddr(lat_idx),
        .wdata(ramstore),
        .raddr(lat_idx),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: LAT=2 instance (a) and LAT=0 instance (b).
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramWEN;
    logic        ramREN;
    logic [31:0] load_a, load_b;
    logic [1:0]  state_a, state_b;

    int total;
    int bad;

    ram_responder #(.LAT(2), .DEPTH(1024)) dut_a (
        .CLK(CLK), .nRST(nRST), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramWEN(ramWEN), .ramREN(ramREN), .ramload(load_a), .ramstate(state_a)
    );

    ram_responder #(.LAT(0), .DEPTH(1024)) dut_b (
        .CLK(CLK), .nRST(nRST), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramWEN(ramWEN), .ramREN(ramREN), .ramload(load_b), .ramstate(state_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Holds one request until ACCESS (bounded); any non-BUSY wait cycle adds 100.
    task automatic run_access(input bit useb, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              output int nbusy, output logic [31:0] ld,
                              output bit ok);
        logic [1:0] st;
        bit seen;
        nbusy = 0;
        ld    = '0;
        seen  = 1'b0;
        @(posedge CLK); #1;
        ramaddr  = a;
        ramstore = d;
        ramWEN   = w;
        ramREN   = ~w;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge CLK);
            st = useb ? state_b : state_a;
            if (st == ACCESS) begin
                seen = 1'b1;
                ld   = useb ? load_b : load_a;
            end else begin
                if (st == BUSY) nbusy++;
                else nbusy += 100;
                @(posedge CLK); #1;
            end
        end
        ok = seen;
        @(posedge CLK); #1;
        ramWEN = 1'b0;
        ramREN = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b1;
        ramREN = 1'b1;
        ramaddr = 32'h40;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (state_a !== FREE) begin
            bad++; $display("FAIL rst_state_a: got %0d want %0d", state_a, FREE);
        end
        total++;
        if (load_a !== 32'h0) begin
            bad++; $display("FAIL rst_load_a: got %h want 0", load_a);
        end
        total++;
        if (state_b !== FREE) begin
            bad++; $display("FAIL rst_state_b: got %0d want %0d", state_b, FREE);
        end
        @(posedge CLK); #1;
        ramREN = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        total++;
        if (state_a !== FREE) begin
            bad++; $display("FAIL idle_state: got %0d want %0d", state_a, FREE);
        end
    endtask

    task automatic test_read_latency();
        @(posedge CLK); #1;
        ramaddr = 32'h40;
        ramREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (state_a !== BUSY || load_a !== 32'h0) begin
                bad++;
                $display("FAIL rd_busy%0d: state=%0d load=%h want state=%0d load=0",
                         i, state_a, load_a, BUSY);
            end
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        total++;
        if (state_a !== ACCESS || load_a !== 32'h0) begin
            bad++;
            $display("FAIL rd_access: state=%0d load=%h want state=%0d load=0",
                     state_a, load_a, ACCESS);
        end
        @(posedge CLK); #1;
        ramREN = 1'b0;
        @(negedge CLK);
        total++;
        if (state_a !== FREE) begin
            bad++; $display("FAIL rd_free: got %0d want %0d", state_a, FREE);
        end
    endtask

    task automatic test_write_read();
        int n;
        logic [31:0] ld;
        bit ok;
        run_access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'h0) begin
            bad++;
            $display("FAIL wr_40: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=0",
                     ok, n, ld);
        end
        run_access(1'b0, 1'b0, 32'h40, 32'h0, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_40: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=deadbeef",
                     ok, n, ld);
        end
        run_access(1'b0, 1'b0, 32'h41, 32'h0, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_41: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=deadbeef",
                     ok, n, ld);
        end
    endtask

    task automatic test_addr_switch();
        int n;
        logic [31:0] ld;
        bit ok;
        run_access(1'b0, 1'b1, 32'h10, 32'h11111111, n, ld, ok);
        run_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, n, ld, ok);
        @(posedge CLK); #1;
        ramaddr = 32'h10;
        ramREN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (state_a !== BUSY) begin
                bad++; $display("FAIL sw_busy%0d: got %0d want %0d", i, state_a, BUSY);
            end
            if (i == 0) begin
                @(posedge CLK); #1;
            end
        end
        run_access(1'b0, 1'b0, 32'h20, 32'h0, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL sw_access: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=cafef00d",
                     ok, n, ld);
        end
    endtask

    task automatic test_error();
        int n;
        logic [31:0] ld;
        bit ok;
        @(posedge CLK); #1;
        ramaddr = 32'h0;
        ramstore = 32'hFFFFFFFF;
        ramWEN = 1'b1;
        ramREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (state_a !== ERROR || load_a !== 32'h0) begin
                bad++;
                $display("FAIL err_both%0d: state=%0d load=%h want state=%0d load=0",
                         i, state_a, load_a, ERROR);
            end
            @(posedge CLK); #1;
        end
        ramaddr = 32'h1000;
        ramWEN = 1'b1;
        ramREN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (state_a !== ERROR) begin
                bad++; $display("FAIL err_range%0d: got %0d want %0d", i, state_a, ERROR);
            end
            @(posedge CLK); #1;
        end
        ramWEN = 1'b0;
        run_access(1'b0, 1'b0, 32'h0, 32'h0, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'h0) begin
            bad++;
            $display("FAIL err_nochange: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=0",
                     ok, n, ld);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] ld;
        bit ok;
        @(posedge CLK); #1;
        ramaddr = 32'h8;
        ramstore = 32'h1234;
        ramWEN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (state_a !== BUSY) begin
                bad++; $display("FAIL mid_busy%0d: got %0d want %0d", i, state_a, BUSY);
            end
            @(posedge CLK); #1;
        end
        nRST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (state_a !== FREE || load_a !== 32'h0) begin
                bad++;
                $display("FAIL mid_rst%0d: state=%0d load=%h want state=%0d load=0",
                         i, state_a, load_a, FREE);
            end
            @(posedge CLK); #1;
        end
        nRST = 1'b0;
        ramWEN = 1'b0;
        run_access(1'b0, 1'b0, 32'h8, 32'h0, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'h0) begin
            bad++;
            $display("FAIL mid_rd8: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=0",
                     ok, n, ld);
        end
        run_access(1'b0, 1'b0, 32'h40, 32'h0, n, ld, ok);
        total++;
        if (!ok || n !== 3 || ld !== 32'h0) begin
            bad++;
            $display("FAIL mid_rd40: seen=%0d busy=%0d load=%h want seen=1 busy=3 load=0",
                     ok, n, ld);
        end
    endtask

    task automatic test_lat0();
        logic        wv [5];
        logic [31:0] av [5];
        logic [31:0] dv [5];
        logic [31:0] ev [5];
        int n;
        logic [31:0] ld;
        bit ok;
        wv[0] = 1'b1; av[0] = 32'h0; dv[0] = 32'hA5A5_0001; ev[0] = 32'h0;
        wv[1] = 1'b0; av[1] = 32'h0; dv[1] = 32'h0;         ev[1] = 32'hA5A5_0001;
        wv[2] = 1'b1; av[2] = 32'h4; dv[2] = 32'h5A5A_0002; ev[2] = 32'h0;
        wv[3] = 1'b0; av[3] = 32'h4; dv[3] = 32'h0;         ev[3] = 32'h5A5A_0002;
        wv[4] = 1'b0; av[4] = 32'h0; dv[4] = 32'h0;         ev[4] = 32'hA5A5_0001;
        for (int i = 0; i < 5; i++) begin
            run_access(1'b1, wv[i], av[i], dv[i], n, ld, ok);
            total++;
            if (!ok || n !== 1 || ld !== ev[i]) begin
                bad++;
                $display("FAIL lat0_%0d: seen=%0d busy=%0d load=%h want seen=1 busy=1 load=%h",
                         i, ok, n, ld, ev[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        nRST = 1'b1;
        ramaddr = '0;
        ramstore = '0;
        ramWEN = 1'b0;
        ramREN = 1'b0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_addr_switch();
        test_error();
        test_reset_mid();
        test_lat0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
